// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the multi-cycle RV32I controller:
//   - RV32I major opcodes used by the sequencer
//   - alu_ctrl_e : ALU operation encoding driven on aluControl
//   - state_e    : sequencer states
//   - pc_src_e   : PC next-value select
//   - wb_sel_e   : register write-back select
//   - dispatch_state() : DECODE-state opcode dispatch
//   - branch_taken()   : branch condition from funct3 and the ALU zero flag
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_e;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        EXEC_U   = 4'd4,
        ALU_WB   = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        ILLEGAL  = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC4  = 2'd2,
        WB_UIMM = 2'd3
    } wb_sel_e;

    // State entered after DECODE for a given major opcode.
    function automatic state_e dispatch_state(input logic [6:0] opcode);
        state_e s;
        case (opcode)
            OP_REG:             s = EXEC_R;
            OP_IMM:             s = EXEC_I;
            OP_LUI, OP_AUIPC:   s = EXEC_U;
            OP_LOAD, OP_STORE:  s = MEM_ADDR;
            OP_BRANCH:          s = BRANCH;
            OP_JAL, OP_JALR:    s = JUMP;
            default:            s = ILLEGAL;
        endcase
        return s;
    endfunction

    // The ALU computes SUB for BEQ/BNE and SLT/SLTU for the ordered compares.
    // For SLT/SLTU the result is 1 (not zero) when rs1 < rs2, so "less than"
    // corresponds to isZero=0.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       is_zero);
        logic taken;
        case (funct3)
            3'b000:         taken = is_zero;    // BEQ
            3'b001:         taken = !is_zero;   // BNE
            3'b100, 3'b110: taken = !is_zero;   // BLT, BLTU
            3'b101, 3'b111: taken = is_zero;    // BGE, BGEU
            default:        taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation decode shared by the R-type, I-type and branch
// execute states.
// Ports:
//   i_funct3      : instr[14:12]
//   i_funct7_5    : instr[30]
//   i_is_alu_reg  : 1 for R-type, 0 for I-type (SUB only exists in R-type)
//   i_is_branch   : 1 selects the compare operation for conditional branches
//   o_alu_ctrl    : decoded ALU operation
// ---------------------------------------------------------------------------
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_is_alu_reg,
    input  logic       i_is_branch,
    output alu_ctrl_e  o_alu_ctrl
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        if (i_is_branch) begin
            case (i_funct3)
                3'b000, 3'b001: o_alu_ctrl = ALU_SUB;
                3'b100, 3'b101: o_alu_ctrl = ALU_SLT;
                3'b110, 3'b111: o_alu_ctrl = ALU_SLTU;
                default:        o_alu_ctrl = ALU_SUB;
            endcase
        end else begin
            case (i_funct3)
                // In I-type, instr[30] is an immediate bit, so ADDI never subtracts.
                3'b000: o_alu_ctrl = (i_is_alu_reg && i_funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001: o_alu_ctrl = ALU_SLL;
                3'b010: o_alu_ctrl = ALU_SLT;
                3'b011: o_alu_ctrl = ALU_SLTU;
                3'b100: o_alu_ctrl = ALU_XOR;
                // SRAI/SRA share the funct7[5] encoding in both formats.
                3'b101: o_alu_ctrl = i_funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110: o_alu_ctrl = ALU_OR;
                3'b111: o_alu_ctrl = ALU_AND;
                default: o_alu_ctrl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Sequencer turning the RV32I datapath into a multi-cycle machine that shares
// one memory port between instruction fetch and load/store.
//
// Configuration macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : an illegal opcode parks the FSM in ILLEGAL with trap=1 until reset
//   undefined : an illegal opcode retires as a NOP, trap tied low
//
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   instr                : IR contents (valid from DECODE onward)
//   isZero               : ALU zero flag
//   mem_ready            : memory completes the current access this cycle
//   mem_req/mem_we       : memory request / store qualifier
//   addr_sel             : 0 = PC address, 1 = ALU result address
//   ir_write, pc_write   : IR / PC write enables
//   pc_src, wb_sel       : PC next-value and write-back selects
//   isALUreg, regWrite, isJAL, isJALR, isBranch : datapath strobes
//   aluControl           : ALU operation
//   retire               : one pulse per completed instruction
//   trap                 : illegal instruction held
// ---------------------------------------------------------------------------
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       instr,
    input  logic                  isZero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  addr_sel,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic [1:0]            wb_sel,
    output logic                  isALUreg,
    output logic                  regWrite,
    output logic                  isJAL,
    output logic                  isJALR,
    output logic                  isBranch,
    output logic [ALU_CTRL_W-1:0] aluControl,
    output logic                  retire,
    output logic                  trap
);

    state_e     r_state;
    alu_ctrl_e  w_dec_alu;
    alu_ctrl_e  w_alu_sel;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_5;
    logic       w_is_reg_op;
    logic       w_is_branch_op;
    logic       w_unused_instr;

    assign w_opcode       = instr[6:0];
    assign w_funct3       = instr[14:12];
    assign w_funct7_5     = instr[30];
    assign w_is_reg_op    = (w_opcode == OP_REG);
    assign w_is_branch_op = (w_opcode == OP_BRANCH);

    // Register/immediate fields are consumed by the datapath, not here.
    assign w_unused_instr = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .i_funct3     (w_funct3),
        .i_funct7_5   (w_funct7_5),
        .i_is_alu_reg (w_is_reg_op),
        .i_is_branch  (w_is_branch_op),
        .o_alu_ctrl   (w_dec_alu)
    );

    // -----------------------------------------------------------------------
    // State sequencing
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:    if (mem_ready) r_state <= DECODE;
                DECODE:   r_state <= dispatch_state(w_opcode);
                EXEC_R,
                EXEC_I,
                EXEC_U:   r_state <= ALU_WB;
                ALU_WB:   r_state <= FETCH;
                MEM_ADDR: r_state <= (w_opcode == OP_STORE) ? MEM_WR : MEM_RD;
                MEM_RD:   if (mem_ready) r_state <= MEM_WB;
                MEM_WB:   r_state <= FETCH;
                MEM_WR:   if (mem_ready) r_state <= FETCH;
                BRANCH,
                JUMP:     r_state <= FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
                ILLEGAL:  r_state <= ILLEGAL;
`else
                ILLEGAL:  r_state <= FETCH;
`endif
                default:  r_state <= FETCH;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode from the registered state.
    // A few strobes must react to mem_ready/isZero in the same cycle (IR load,
    // store completion, branch direction), so outputs are decoded here rather
    // than registered. Masking with reset forces every output low while reset
    // is held, which also drops an in-flight memory request immediately.
    // Outputs of the wait states depend only on r_state, so mem_req, mem_we
    // and addr_sel cannot move before the mem_ready cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        wb_sel    = WB_ALU;
        isALUreg  = 1'b0;
        regWrite  = 1'b0;
        isJAL     = 1'b0;
        isJALR    = 1'b0;
        isBranch  = 1'b0;
        w_alu_sel = ALU_ADD;
        retire    = 1'b0;
        trap      = 1'b0;

        if (!reset) begin
            case (r_state)
                FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                DECODE: begin
                end
                EXEC_R: begin
                    isALUreg  = 1'b1;
                    w_alu_sel = w_dec_alu;
                end
                EXEC_I: begin
                    w_alu_sel = w_dec_alu;
                end
                EXEC_U: begin
                    // AUIPC adds via the default ALU_ADD; LUI bypasses the ALU.
                    if (w_opcode == OP_LUI) wb_sel = WB_UIMM;
                end
                ALU_WB: begin
                    // Keep the execute-cycle operation stable so the write-back
                    // value is still valid while regWrite is high.
                    isALUreg  = w_is_reg_op;
                    if (w_is_reg_op || (w_opcode == OP_IMM)) w_alu_sel = w_dec_alu;
                    if (w_opcode == OP_LUI) wb_sel = WB_UIMM;
                    regWrite  = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                end
                MEM_ADDR: begin
                    w_alu_sel = ALU_ADD;
                end
                MEM_RD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                end
                MEM_WB: begin
                    regWrite = 1'b1;
                    wb_sel   = WB_MEM;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
                MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                    pc_write = mem_ready;
                    retire   = mem_ready;
                end
                BRANCH: begin
                    isBranch  = 1'b1;
                    w_alu_sel = w_dec_alu;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    pc_src    = branch_taken(w_funct3, isZero) ? PC_BRANCH : PC_PLUS4;
                end
                JUMP: begin
                    isJAL    = (w_opcode == OP_JAL);
                    isJALR   = (w_opcode != OP_JAL);
                    regWrite = 1'b1;
                    wb_sel   = WB_PC4;
                    pc_src   = (w_opcode == OP_JAL) ? PC_JAL : PC_JALR;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
                ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    trap     = 1'b1;
`else
                    pc_write = 1'b1;
                    retire   = 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign aluControl = ALU_CTRL_W'(w_alu_sel);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: expected per-cycle output vectors are queued before each
// instruction is driven and popped as the DUT steps through it.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] wb_sel;
        logic       isALUreg;
        logic       regWrite;
        logic       isJAL;
        logic       isJALR;
        logic       isBranch;
        logic [3:0] alu;
        logic       retire;
        logic       trap;
    } outv_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        isZero;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src, wb_sel;
    logic        isALUreg, regWrite, isJAL, isJALR, isBranch;
    logic [3:0]  aluControl;
    logic        retire, trap;

    outv_t       w_obs;
    outv_t       exp_q[$];
    string       tag_q[$];
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .isZero     (isZero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .wb_sel     (wb_sel),
        .isALUreg   (isALUreg),
        .regWrite   (regWrite),
        .isJAL      (isJAL),
        .isJALR     (isJALR),
        .isBranch   (isBranch),
        .aluControl (aluControl),
        .retire     (retire),
        .trap       (trap)
    );

    assign w_obs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, wb_sel,
                    isALUreg, regWrite, isJAL, isJALR, isBranch, aluControl, retire, trap};

    task automatic check(input outv_t e, input string tag);
        n_total++;
        assert (w_obs === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, w_obs, e);
        end
    endtask

    task automatic push(input outv_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // One clock cycle: drive inputs at the falling edge, compare before the rising edge.
    task automatic step(input logic [31:0] ins, input logic rdy, input logic z);
        outv_t e;
        string t;
        @(negedge clk);
        instr     = ins;
        mem_ready = rdy;
        isZero    = z;
        #2;
        if (exp_q.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed=%05h expected=none", w_obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(e, t);
        end
    endtask

    function automatic outv_t v_fetch(input logic rdy);
        outv_t v = '0;
        v.mem_req  = 1'b1;
        v.ir_write = rdy;
        return v;
    endfunction

    // R/I/U instruction: FETCH, DECODE, EXEC, ALU_WB with mem_ready=1.
    task automatic run_alu(input logic [31:0] ins, input logic isreg,
                           input logic [3:0] alu, input logic [1:0] wb, input string nm);
        outv_t e;
        push(v_fetch(1'b1), {nm, "_fetch"});
        push('0, {nm, "_decode"});
        e = '0;
        e.isALUreg = isreg;
        e.alu      = alu;
        e.wb_sel   = wb;
        push(e, {nm, "_exec"});
        e.regWrite = 1'b1;
        e.pc_write = 1'b1;
        e.retire   = 1'b1;
        push(e, {nm, "_wb"});
        repeat (4) step(ins, 1'b1, 1'b0);
    endtask

    task automatic run_br(input logic [31:0] ins, input logic z, input logic [3:0] alu,
                          input logic taken, input string nm);
        outv_t e;
        push(v_fetch(1'b1), {nm, "_fetch"});
        push('0, {nm, "_decode"});
        e = '0;
        e.isBranch = 1'b1;
        e.pc_write = 1'b1;
        e.retire   = 1'b1;
        e.alu      = alu;
        e.pc_src   = taken ? 2'd1 : 2'd0;
        push(e, {nm, "_branch"});
        repeat (3) step(ins, 1'b1, z);
    endtask

    task automatic run_jump(input logic [31:0] ins, input logic is_jal, input string nm);
        outv_t e;
        push(v_fetch(1'b1), {nm, "_fetch"});
        push('0, {nm, "_decode"});
        e = '0;
        e.isJAL    = is_jal;
        e.isJALR   = !is_jal;
        e.regWrite = 1'b1;
        e.wb_sel   = 2'd2;
        e.pc_src   = is_jal ? 2'd2 : 2'd3;
        e.pc_write = 1'b1;
        e.retire   = 1'b1;
        push(e, {nm, "_jump"});
        repeat (3) step(ins, 1'b1, 1'b0);
    endtask

    initial begin
        outv_t e;
        reset     = 1'b1;
        instr     = '0;
        mem_ready = 1'b1;
        isZero    = 1'b0;

        // Reset: every output low even with mem_ready high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check('0, "in_reset");
        @(negedge clk);
        mem_ready = 1'b0;
        reset     = 1'b0;
        #2;
        check(v_fetch(1'b0), "fetch_after_reset");

        // ALU / U-type
        run_alu(32'h002081B3, 1'b1, 4'd0, 2'd0, "add");
        run_alu(32'h40208133, 1'b1, 4'd1, 2'd0, "sub");
        run_alu(32'h0020F1B3, 1'b1, 4'd9, 2'd0, "and");
        run_alu(32'h4030D093, 1'b0, 4'd7, 2'd0, "srai");
        run_alu(32'h40000093, 1'b0, 4'd0, 2'd0, "addi_b30");
        run_alu(32'h123450B7, 1'b0, 4'd0, 2'd3, "lui");
        run_alu(32'h12345097, 1'b0, 4'd0, 2'd0, "auipc");

        // Load with two wait cycles in MEM_RD: 7 cycles total.
        push(v_fetch(1'b1), "lw_fetch");
        push('0, "lw_decode");
        push('0, "lw_addr");
        e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1;
        push(e, "lw_rd_wait0");
        push(e, "lw_rd_wait1");
        push(e, "lw_rd_ready");
        e = '0; e.regWrite = 1'b1; e.wb_sel = 2'd1; e.pc_write = 1'b1; e.retire = 1'b1;
        push(e, "lw_wb");
        step(32'h0000A183, 1'b1, 1'b0);
        step(32'h0000A183, 1'b1, 1'b0);
        step(32'h0000A183, 1'b1, 1'b0);
        step(32'h0000A183, 1'b0, 1'b0);
        step(32'h0000A183, 1'b0, 1'b0);
        step(32'h0000A183, 1'b1, 1'b0);
        step(32'h0000A183, 1'b1, 1'b0);

        // Store with one fetch wait and one MEM_WR wait.
        push(v_fetch(1'b0), "sw_fetch_wait");
        push(v_fetch(1'b1), "sw_fetch");
        push('0, "sw_decode");
        push('0, "sw_addr");
        e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 1'b1;
        push(e, "sw_wr_wait");
        e.pc_write = 1'b1; e.retire = 1'b1;
        push(e, "sw_wr_ready");
        step(32'h0020A023, 1'b0, 1'b0);
        step(32'h0020A023, 1'b1, 1'b0);
        step(32'h0020A023, 1'b1, 1'b0);
        step(32'h0020A023, 1'b1, 1'b0);
        step(32'h0020A023, 1'b0, 1'b0);
        step(32'h0020A023, 1'b1, 1'b0);

        // Branches: direction from funct3 and isZero.
        run_br(32'h00208463, 1'b1, 4'd1, 1'b1, "beq_z1");
        run_br(32'h00208463, 1'b0, 4'd1, 1'b0, "beq_z0");
        run_br(32'h00209463, 1'b0, 4'd1, 1'b1, "bne_z0");
        run_br(32'h0020C463, 1'b0, 4'd3, 1'b1, "blt_z0");
        run_br(32'h0020D463, 1'b0, 4'd3, 1'b0, "bge_z0");
        run_br(32'h0020E463, 1'b1, 4'd4, 1'b0, "bltu_z1");
        run_br(32'h0020F463, 1'b1, 4'd4, 1'b1, "bgeu_z1");

        // Jumps
        run_jump(32'h008000EF, 1'b1, "jal");
        run_jump(32'h000100E7, 1'b0, "jalr");

        // Reset during MEM_WR wait: request drops without a clock edge.
        push(v_fetch(1'b1), "rst_sw_fetch");
        push('0, "rst_sw_decode");
        push('0, "rst_sw_addr");
        e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 1'b1;
        push(e, "rst_sw_wait");
        step(32'h0020A023, 1'b1, 1'b0);
        step(32'h0020A023, 1'b1, 1'b0);
        step(32'h0020A023, 1'b1, 1'b0);
        step(32'h0020A023, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check('0, "rst_async_drop");
        @(negedge clk);
        #2;
        check('0, "rst_held");
        mem_ready = 1'b0;
        reset     = 1'b0;
        #1;
        check(v_fetch(1'b0), "rst_release_fetch");
        run_alu(32'h002081B3, 1'b1, 4'd0, 2'd0, "add_after_rst");

        // Illegal opcode
        push(v_fetch(1'b1), "ill_fetch");
        push('0, "ill_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
        e = '0; e.trap = 1'b1;
        push(e, "ill_trap0");
        push(e, "ill_trap1");
        push(e, "ill_trap2");
        push(e, "ill_trap3");
        repeat (6) step(32'hFFFFFFFF, 1'b1, 1'b0);
`else
        e = '0; e.pc_write = 1'b1; e.retire = 1'b1;
        push(e, "ill_nop");
        push(v_fetch(1'b1), "ill_refetch");
        repeat (4) step(32'hFFFFFFFF, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
